// File: rtl/display_7seg.sv
// rtl/display_7seg.sv - binary-to-BCD (double dabble) converter with multiplexed 7-segment scan
// Converts the 8-bit press count, latches the BCD result and scans three digits with leading-zero blanking.
module display_7seg #(
  parameter int SCAN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic [7:0]  conta_i,
  output logic [11:0] bcd_o,
  output logic        valid_o,
  output logic [3:0]  anodo_o,
  output logic [6:0]  seg_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [19:0]   shift_q, shift_d, adj;
  logic [2:0]    step_q, step_d;
  logic [7:0]    snap_q, snap_d;
  logic [7:0]    last_q, last_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          valid_q, valid_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    anodo_q, anodo_d;
  logic [6:0]    seg_q, seg_d;

  logic [3:0] nib;
  logic       blank;

  always_comb begin
    adj = shift_q;
    if (shift_q[11:8]  >= 4'd5) adj[11:8]  = shift_q[11:8]  + 4'd3;
    if (shift_q[15:12] >= 4'd5) adj[15:12] = shift_q[15:12] + 4'd3;
    if (shift_q[19:16] >= 4'd5) adj[19:16] = shift_q[19:16] + 4'd3;
  end

  // Input changes are only sampled in IDLE, so a conversion always runs to completion.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    step_d  = step_q;
    snap_d  = snap_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (conta_i != last_q) begin
          shift_d = {12'b0, conta_i};
          snap_d  = conta_i;
          step_d  = 3'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        shift_d = {adj[18:0], 1'b0};
        step_d  = step_q + 3'd1;
        if (step_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        bcd_d   = shift_q[19:8];
        last_d  = snap_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_comb begin
    nib     = 4'd0;
    blank   = 1'b1;
    anodo_d = 4'b1111;
    case (idx_q)
      2'd0: begin nib = bcd_q[3:0];  anodo_d = 4'b1110; blank = 1'b0; end
      2'd1: begin nib = bcd_q[7:4];  anodo_d = 4'b1101; blank = (bcd_q[11:4] == 8'd0); end
      2'd2: begin nib = bcd_q[11:8]; anodo_d = 4'b1011; blank = (bcd_q[11:8] == 4'd0); end
      default: ;
    endcase
    case (nib)
      4'd0: seg_d = 7'b1000000;
      4'd1: seg_d = 7'b1111001;
      4'd2: seg_d = 7'b0100100;
      4'd3: seg_d = 7'b0110000;
      4'd4: seg_d = 7'b0011001;
      4'd5: seg_d = 7'b0010010;
      4'd6: seg_d = 7'b0000010;
      4'd7: seg_d = 7'b1111000;
      4'd8: seg_d = 7'b0000000;
      4'd9: seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
    if (blank) begin
      anodo_d = 4'b1111;
      seg_d   = 7'b1111111;
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      step_q  <= '0;
      snap_q  <= '0;
      last_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      anodo_q <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      step_q  <= step_d;
      snap_q  <= snap_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      anodo_q <= anodo_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd_o   = bcd_q;
  assign valid_o = valid_q;
  assign anodo_o = anodo_q;
  assign seg_o   = seg_q;

endmodule

// File: tb/tb_display_7seg.sv
// tb/tb_display_7seg.sv - scoreboard bench for display_7seg
// Expected BCD/cycle pairs are queued at stimulus time and popped by a monitor on each valid_o pulse.
module tb_display_7seg;

  localparam int SC = 2;

  logic        clk;
  logic        clk_run;
  logic        reset_ni;
  logic [7:0]  conta_i;
  logic [11:0] bcd_o;
  logic        valid_o;
  logic [3:0]  anodo_o;
  logic [6:0]  seg_o;

  typedef struct {
    logic [11:0] bcd;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   pushed = 0;
  int   model_last = 0;

  display_7seg #(.SCAN_CYCLES(SC)) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .conta_i  (conta_i),
    .bcd_o    (bcd_o),
    .valid_o  (valid_o),
    .anodo_o  (anodo_o),
    .seg_o    (seg_o)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_conv(input int v, input int at_cyc);
    q.push_back('{to_bcd(v), at_cyc});
    pushed++;
    model_last = v;
  endtask

  task automatic set_val(input int v);
    @(negedge clk);
    conta_i = 8'(v);
    if (v != model_last) expect_conv(v, cyc + 10);
  endtask

  // Two full frames: each shown digit must occupy exactly 2*SC cycles with its own code.
  task automatic check_display(input int v);
    int nu = 0, nt = 0, nh = 0, nb = 0, bad = 0;
    repeat (6 * SC) begin
      @(negedge clk);
      case (anodo_o)
        4'b1110: begin nu++; if (seg_o != seg_of(v % 10)) bad++; end
        4'b1101: begin nt++; if (seg_o != seg_of((v / 10) % 10)) bad++; end
        4'b1011: begin nh++; if (seg_o != seg_of(v / 100)) bad++; end
        4'b1111: begin nb++; if (seg_o != 7'b1111111) bad++; end
        default: bad++;
      endcase
    end
    chk($sformatf("units_slots_%0d", v), nu, 2 * SC);
    chk($sformatf("tens_slots_%0d", v), nt, (v >= 10) ? 2 * SC : 0);
    chk($sformatf("hund_slots_%0d", v), nh, (v >= 100) ? 2 * SC : 0);
    chk($sformatf("blank_slots_%0d", v), nb, 6 * SC - nu - ((v >= 10) ? 2 * SC : 0) - ((v >= 100) ? 2 * SC : 0));
    chk($sformatf("seg_codes_%0d", v), bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, m, v;
    clk = 1'b0;
    clk_run = 1'b1;
    reset_ni = 1'b0;
    conta_i = 8'd0;

    fork
      forever begin
        @(negedge clk);
        if (reset_ni && valid_o) begin
          exp_t e;
          pulses++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got bcd %0h expected no pulse (cycle %0d)", bcd_o, cyc);
          end else begin
            e = q.pop_front();
            chk("valid_bcd", bcd_o, e.bcd);
            chk("valid_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    // Reset values
    wait_n(3);
    chk("rst_anodo", anodo_o, 4'b1111);
    chk("rst_seg", seg_o, 7'b1111111);
    chk("rst_bcd", bcd_o, 12'h000);
    chk("rst_valid", valid_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    wait_n(1);
    chk("first_anodo", anodo_o, 4'b1110);
    chk("first_seg", seg_o, 7'b1000000);
    wait_n(12);
    chk("idle_bcd", bcd_o, 12'h000);

    // Full scale
    set_val(255);
    wait_n(12);
    check_display(255);

    // Asynchronous reset with the clock stopped
    @(negedge clk);
    clk_run = 1'b0;
    #20;
    reset_ni = 1'b0;
    conta_i = 8'd0;
    #2;
    chk("async_anodo", anodo_o, 4'b1111);
    chk("async_seg", seg_o, 7'b1111111);
    chk("async_bcd", bcd_o, 12'h000);
    chk("async_valid", valid_o, 0);
    #10;
    clk_run = 1'b1;
    wait_n(2);
    reset_ni = 1'b1;
    model_last = 0;
    wait_n(2);

    // Leading-zero blanking and the 99/100 boundary
    set_val(7);
    wait_n(12);
    check_display(7);
    set_val(99);
    wait_n(12);
    check_display(99);
    set_val(100);
    wait_n(12);
    check_display(100);

    // Input change mid-conversion: 37 completes, 200 follows at E10
    @(negedge clk);
    conta_i = 8'd37;
    n = cyc;
    expect_conv(37, n + 10);
    wait_n(3);
    conta_i = 8'd200;
    expect_conv(200, n + 20);
    wait_n(21);
    check_display(200);

    // Reset at E4 of a conversion, then reconversion after release
    set_val(0);
    wait_n(12);
    check_display(0);
    @(negedge clk);
    conta_i = 8'd150;
    wait_n(5);
    reset_ni = 1'b0;
    #1;
    chk("midconv_bcd", bcd_o, 12'h000);
    chk("midconv_valid", valid_o, 0);
    wait_n(2);
    reset_ni = 1'b1;
    m = cyc;
    model_last = 0;
    expect_conv(150, m + 10);
    wait_n(9);
    chk("reconv_hold_bcd", bcd_o, 12'h000);
    wait_n(3);
    check_display(150);

    // Randomized values
    for (int i = 0; i < 15; i++) begin
      v = int'($urandom_range(0, 255));
      set_val(v);
      wait_n(12);
      check_display(v);
    end

    wait_n(15);
    chk("queue_empty", q.size(), 0);
    chk("pulse_count", pulses, pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
